// File: rtl/mem_align_unit_pkg.sv
// Shared types for the memory alignment unit: LSU op codes, FSM states, op decode helpers.
// No logic or state lives here.
// Imported by the top level, the lane shifter and the bench.
package mem_align_unit_pkg;

   typedef enum logic [2:0] {
      MEM_NO, MEM_B, MEM_H, MEM_W, MEM_D, MEM_UB, MEM_UH, MEM_UW
   } mem_op_enum;

   typedef enum logic [2:0] {
      IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE, ERR
   } align_state_t;

   function automatic logic [3:0] size_of(input mem_op_enum op);
      case (op)
         MEM_B, MEM_UB: size_of = 4'd1;
         MEM_H, MEM_UH: size_of = 4'd2;
         MEM_W, MEM_UW: size_of = 4'd4;
         MEM_D:         size_of = 4'd8;
         default:       size_of = 4'd0;
      endcase
   endfunction

   function automatic logic is_signed_op(input mem_op_enum op);
      is_signed_op = (op == MEM_B) || (op == MEM_H) || (op == MEM_W) || (op == MEM_D);
   endfunction

endpackage

// File: rtl/mem_lane_shift.sv
// Byte-lane steering: wide store mask/data over two bus words, and load merge with extension.
// Latency: purely combinational.
// Backpressure: none; the caller holds inputs stable while a beat is pending.
module mem_lane_shift
   import mem_align_unit_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [3:0]                     i_size,
   input  logic                           i_signed,
   input  logic [$clog2(DATA_W/8)-1:0]    i_off,
   input  logic [63:0]                    i_wdata,
   input  logic [2*DATA_W-1:0]            i_rdata_wide,
   output logic [2*(DATA_W/8)-1:0]        o_mask_wide,
   output logic [2*DATA_W-1:0]            o_wdata_wide,
   output logic [63:0]                    o_rdata
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = $clog2(BYTES);

   logic [7:0]       w_size_mask;
   logic [OFF_W+2:0] w_bit_sh;
   logic [63:0]      w_raw;

   always_comb begin
      w_size_mask = 8'h00;
      case (i_size)
         4'd1:    w_size_mask = 8'h01;
         4'd2:    w_size_mask = 8'h03;
         4'd4:    w_size_mask = 8'h0F;
         4'd8:    w_size_mask = 8'hFF;
         default: w_size_mask = 8'h00;
      endcase
   end

   assign w_bit_sh     = {i_off, 3'b000};
   assign o_mask_wide  = {{(2*BYTES-8){1'b0}}, w_size_mask} << i_off;
   assign o_wdata_wide = {{(2*DATA_W-64){1'b0}}, i_wdata} << w_bit_sh;

   // Only the low 64 bits of the merged pair can ever hold the addressed bytes.
   assign w_raw = 64'(i_rdata_wide >> w_bit_sh);

   always_comb begin
      o_rdata = 64'd0;
      case (i_size)
         4'd1:    o_rdata = {{56{i_signed & w_raw[7]}},  w_raw[7:0]};
         4'd2:    o_rdata = {{48{i_signed & w_raw[15]}}, w_raw[15:0]};
         4'd4:    o_rdata = {{32{i_signed & w_raw[31]}}, w_raw[31:0]};
         4'd8:    o_rdata = w_raw;
         default: o_rdata = 64'd0;
      endcase
   end

endmodule

// File: rtl/mem_align_unit.sv
// LSU-to-bus aligner: one or two bus beats per scalar access, split or faulted on word crossing.
// Latency: aligned store rsp T+2, split store T+3, loads T+3/T+5 with 1-cycle rvalid, fault T+1.
// Backpressure: req_ready only in IDLE; beats hold until bus_ready; rsp is a pulse with no stall.
module mem_align_unit
   import mem_align_unit_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int ADDR_W      = 64,
   parameter bit MISALIGN_EN = 1'b1
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [ADDR_W-1:0]      req_addr,
   input  mem_op_enum             req_op,
   input  logic                   req_we,
   input  logic [63:0]            req_wdata,
   output logic                   rsp_valid,
   output logic [63:0]            rsp_rdata,
   output logic                   rsp_fault,
   output logic                   bus_valid,
   input  logic                   bus_ready,
   output logic [ADDR_W-1:0]      bus_addr,
   output logic                   bus_we,
   output logic [DATA_W-1:0]      bus_wdata,
   output logic [DATA_W/8-1:0]    bus_wmask,
   input  logic                   bus_rvalid,
   input  logic [DATA_W-1:0]      bus_rdata
);

   localparam int                BYTES       = DATA_W / 8;
   localparam int                OFF_W       = $clog2(BYTES);
   localparam logic [7:0]        BYTES_8     = 8'(BYTES);
   localparam logic [ADDR_W-1:0] BEAT_STRIDE = ADDR_W'(BYTES);

   align_state_t      r_state;
   logic [ADDR_W-1:0] r_addr;
   mem_op_enum        r_op;
   logic              r_we;
   logic [63:0]       r_wdata;
   logic              r_cross;
   logic              r_misal;
   logic [DATA_W-1:0] r_rdata0;
   logic [DATA_W-1:0] r_rdata1;

   logic [3:0]          w_req_size;
   logic [OFF_W-1:0]    w_req_off;
   logic                w_req_cross;
   logic                w_req_misal;
   logic                w_req_err;
   logic                w_beat1;
   logic [ADDR_W-1:0]   w_base_addr;
   logic [2*BYTES-1:0]  w_mask_wide;
   logic [2*DATA_W-1:0] w_wdata_wide;
   logic [63:0]         w_load_data;

   // Request decode happens before capture so the FSM knows fault/split at accept time.
   assign w_req_size  = size_of(req_op);
   assign w_req_off   = req_addr[OFF_W-1:0];
   assign w_req_cross = (8'(w_req_off) + 8'(w_req_size)) > BYTES_8;

   always_comb begin
      w_req_misal = 1'b0;
      case (w_req_size)
         4'd2:    w_req_misal = req_addr[0];
         4'd4:    w_req_misal = |req_addr[1:0];
         4'd8:    w_req_misal = |req_addr[2:0];
         default: w_req_misal = 1'b0;
      endcase
   end

   assign w_req_err = (req_op == MEM_NO) || (w_req_misal && !MISALIGN_EN);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state  <= IDLE;
         r_addr   <= '0;
         r_op     <= MEM_NO;
         r_we     <= 1'b0;
         r_wdata  <= 64'd0;
         r_cross  <= 1'b0;
         r_misal  <= 1'b0;
         r_rdata0 <= '0;
         r_rdata1 <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_addr   <= req_addr;
                  r_op     <= req_op;
                  r_we     <= req_we;
                  r_wdata  <= req_wdata;
                  r_cross  <= w_req_cross;
                  r_misal  <= w_req_misal;
                  r_rdata0 <= '0;
                  r_rdata1 <= '0;
                  if (w_req_err) r_state <= ERR;
                  else           r_state <= REQ0;
               end
            end
            REQ0: begin
               if (bus_ready) begin
                  if (!r_we)        r_state <= WAIT0;
                  else if (r_cross) r_state <= REQ1;
                  else              r_state <= DONE;
               end
            end
            WAIT0: begin
               if (bus_rvalid) begin
                  r_rdata0 <= bus_rdata;
                  if (r_cross) r_state <= REQ1;
                  else         r_state <= DONE;
               end
            end
            REQ1: begin
               if (bus_ready) begin
                  if (r_we) r_state <= DONE;
                  else      r_state <= WAIT1;
               end
            end
            WAIT1: begin
               if (bus_rvalid) begin
                  r_rdata1 <= bus_rdata;
                  r_state  <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   mem_lane_shift #(.DATA_W(DATA_W)) u_lane_shift (
      .i_size       (size_of(r_op)),
      .i_signed     (is_signed_op(r_op)),
      .i_off        (r_addr[OFF_W-1:0]),
      .i_wdata      (r_wdata),
      .i_rdata_wide ({r_rdata1, r_rdata0}),
      .o_mask_wide  (w_mask_wide),
      .o_wdata_wide (w_wdata_wide),
      .o_rdata      (w_load_data)
   );

   // All bus outputs decode from registered state, so an async reset clears them at once.
   assign req_ready   = (r_state == IDLE);
   assign bus_valid   = (r_state == REQ0) || (r_state == REQ1);
   assign w_beat1     = (r_state == REQ1);
   assign w_base_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign bus_addr    = w_beat1 ? (w_base_addr + BEAT_STRIDE) : w_base_addr;
   assign bus_we      = bus_valid & r_we;
   assign bus_wdata   = !bus_we ? '0 :
                        w_beat1 ? w_wdata_wide[2*DATA_W-1:DATA_W] : w_wdata_wide[DATA_W-1:0];
   assign bus_wmask   = !bus_we ? '0 :
                        w_beat1 ? w_mask_wide[2*BYTES-1:BYTES] : w_mask_wide[BYTES-1:0];

   assign rsp_valid = (r_state == DONE) || (r_state == ERR);
   assign rsp_fault = (r_state == ERR) && r_misal;
   assign rsp_rdata = ((r_state == DONE) && !r_we) ? w_load_data : 64'd0;

endmodule

// File: tb/tb_mem_align_unit.sv
// Directed bench for mem_align_unit: default config, a faulting config and a 128-bit bus config.
module tb_mem_align_unit;
   import mem_align_unit_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // a_: DATA_W=64 MISALIGN_EN=1, f_: DATA_W=64 MISALIGN_EN=0, x_: DATA_W=128 MISALIGN_EN=1
   logic        a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_fault;
   logic [63:0] a_req_addr, a_req_wdata, a_rsp_rdata;
   mem_op_enum  a_req_op;
   logic        a_bus_valid, a_bus_ready, a_bus_we, a_bus_rvalid;
   logic [63:0] a_bus_addr, a_bus_wdata, a_bus_rdata;
   logic [7:0]  a_bus_wmask;

   logic        f_req_valid, f_req_ready, f_req_we, f_rsp_valid, f_rsp_fault;
   logic [63:0] f_req_addr, f_req_wdata, f_rsp_rdata;
   mem_op_enum  f_req_op;
   logic        f_bus_valid, f_bus_ready, f_bus_we, f_bus_rvalid;
   logic [63:0] f_bus_addr, f_bus_wdata, f_bus_rdata;
   logic [7:0]  f_bus_wmask;

   logic         x_req_valid, x_req_ready, x_req_we, x_rsp_valid, x_rsp_fault;
   logic [63:0]  x_req_addr, x_req_wdata, x_rsp_rdata;
   mem_op_enum   x_req_op;
   logic         x_bus_valid, x_bus_ready, x_bus_we, x_bus_rvalid;
   logic [63:0]  x_bus_addr;
   logic [127:0] x_bus_wdata, x_bus_rdata;
   logic [15:0]  x_bus_wmask;

   mem_align_unit #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(1'b1)) u_dut_a (
      .clk(clk), .rstn(rstn), .req_valid(a_req_valid), .req_ready(a_req_ready),
      .req_addr(a_req_addr), .req_op(a_req_op), .req_we(a_req_we), .req_wdata(a_req_wdata),
      .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_fault(a_rsp_fault),
      .bus_valid(a_bus_valid), .bus_ready(a_bus_ready), .bus_addr(a_bus_addr), .bus_we(a_bus_we),
      .bus_wdata(a_bus_wdata), .bus_wmask(a_bus_wmask), .bus_rvalid(a_bus_rvalid), .bus_rdata(a_bus_rdata));

   mem_align_unit #(.DATA_W(64), .ADDR_W(64), .MISALIGN_EN(1'b0)) u_dut_f (
      .clk(clk), .rstn(rstn), .req_valid(f_req_valid), .req_ready(f_req_ready),
      .req_addr(f_req_addr), .req_op(f_req_op), .req_we(f_req_we), .req_wdata(f_req_wdata),
      .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .rsp_fault(f_rsp_fault),
      .bus_valid(f_bus_valid), .bus_ready(f_bus_ready), .bus_addr(f_bus_addr), .bus_we(f_bus_we),
      .bus_wdata(f_bus_wdata), .bus_wmask(f_bus_wmask), .bus_rvalid(f_bus_rvalid), .bus_rdata(f_bus_rdata));

   mem_align_unit #(.DATA_W(128), .ADDR_W(64), .MISALIGN_EN(1'b1)) u_dut_x (
      .clk(clk), .rstn(rstn), .req_valid(x_req_valid), .req_ready(x_req_ready),
      .req_addr(x_req_addr), .req_op(x_req_op), .req_we(x_req_we), .req_wdata(x_req_wdata),
      .rsp_valid(x_rsp_valid), .rsp_rdata(x_rsp_rdata), .rsp_fault(x_rsp_fault),
      .bus_valid(x_bus_valid), .bus_ready(x_bus_ready), .bus_addr(x_bus_addr), .bus_we(x_bus_we),
      .bus_wdata(x_bus_wdata), .bus_wmask(x_bus_wmask), .bus_rvalid(x_bus_rvalid), .bus_rdata(x_bus_rdata));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input mem_op_enum op, input logic [63:0] addr, input logic we,
                          input logic [63:0] wd);
      a_req_valid = 1'b1;
      a_req_op    = op;
      a_req_addr  = addr;
      a_req_we    = we;
      a_req_wdata = wd;
   endtask

   task automatic test_reset;
      checks++; if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready: got %b exp 1", a_req_ready); end
      checks++; if ({a_bus_valid, a_bus_we, a_rsp_valid, a_rsp_fault} !== 4'b0000) begin
         errors++; $display("FAIL reset ctrl: got %b exp 0000", {a_bus_valid, a_bus_we, a_rsp_valid, a_rsp_fault}); end
      checks++; if ({a_bus_addr, a_bus_wdata, a_bus_wmask, a_rsp_rdata} !== 200'd0) begin
         errors++; $display("FAIL reset data: addr %h wdata %h wmask %h rdata %h exp all 0",
                            a_bus_addr, a_bus_wdata, a_bus_wmask, a_rsp_rdata); end
   endtask

   task automatic test_store_aligned;
      drive_a(MEM_W, 64'h1004, 1'b1, 64'hDEADBEEF);
      tick; a_req_valid = 1'b0;
      checks++; if ({a_bus_valid, a_bus_we, a_req_ready} !== 3'b110) begin
         errors++; $display("FAIL st_w ctrl: got %b exp 110", {a_bus_valid, a_bus_we, a_req_ready}); end
      checks++; if ({a_bus_addr, a_bus_wmask, a_bus_wdata} !== {64'h1000, 8'hF0, 64'hDEADBEEF_00000000}) begin
         errors++; $display("FAIL st_w beat: addr %h mask %h data %h exp 1000 f0 deadbeef00000000",
                            a_bus_addr, a_bus_wmask, a_bus_wdata); end
      checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL st_w early rsp: got %b exp 0", a_rsp_valid); end
      tick;
      checks++; if ({a_rsp_valid, a_bus_valid, a_rsp_rdata} !== {2'b10, 64'd0}) begin
         errors++; $display("FAIL st_w rsp T+2: valid %b busv %b rdata %h exp 1 0 0", a_rsp_valid, a_bus_valid, a_rsp_rdata); end
      tick;
      checks++; if ({a_rsp_valid, a_req_ready} !== 2'b01) begin
         errors++; $display("FAIL st_w idle: got %b exp 01", {a_rsp_valid, a_req_ready}); end
      // misaligned but within one word: a single beat
      drive_a(MEM_W, 64'h1002, 1'b1, 64'hCAFEF00D);
      tick; a_req_valid = 1'b0;
      checks++; if ({a_bus_addr, a_bus_wmask, a_bus_wdata} !== {64'h1000, 8'h3C, 64'h0000CAFE_F00D0000}) begin
         errors++; $display("FAIL st_w_mis beat: addr %h mask %h data %h exp 1000 3c 0000cafef00d0000",
                            a_bus_addr, a_bus_wmask, a_bus_wdata); end
      tick;
      checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL st_w_mis rsp: got %b exp 1", a_rsp_valid); end
      tick;
   endtask

   task automatic test_store_split;
      drive_a(MEM_D, 64'h2006, 1'b1, 64'h1122334455667788);
      tick; a_req_valid = 1'b0;
      checks++; if ({a_bus_valid, a_bus_addr, a_bus_wmask, a_bus_wdata} !== {1'b1, 64'h2000, 8'hC0, 64'h7788000000000000}) begin
         errors++; $display("FAIL st_d beat0: v %b addr %h mask %h data %h exp 1 2000 c0 7788000000000000",
                            a_bus_valid, a_bus_addr, a_bus_wmask, a_bus_wdata); end
      tick;
      checks++; if ({a_bus_valid, a_bus_addr, a_bus_wmask, a_bus_wdata} !== {1'b1, 64'h2008, 8'h3F, 64'h0000112233445566}) begin
         errors++; $display("FAIL st_d beat1: v %b addr %h mask %h data %h exp 1 2008 3f 0000112233445566",
                            a_bus_valid, a_bus_addr, a_bus_wmask, a_bus_wdata); end
      checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL st_d early rsp: got %b exp 0", a_rsp_valid); end
      tick;
      checks++; if ({a_rsp_valid, a_bus_valid} !== 2'b10) begin
         errors++; $display("FAIL st_d rsp T+3: got %b exp 10", {a_rsp_valid, a_bus_valid}); end
      tick;
   endtask

   task automatic test_load_aligned;
      drive_a(MEM_W, 64'h3004, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
      tick; a_req_valid = 1'b0;
      checks++; if ({a_bus_valid, a_bus_we, a_bus_addr, a_bus_wmask, a_bus_wdata} !== {2'b10, 64'h3000, 8'h00, 64'd0}) begin
         errors++; $display("FAIL ld_w read beat: v %b we %b addr %h mask %h data %h exp 1 0 3000 00 0",
                            a_bus_valid, a_bus_we, a_bus_addr, a_bus_wmask, a_bus_wdata); end
      tick;
      checks++; if ({a_bus_valid, a_rsp_valid} !== 2'b00) begin
         errors++; $display("FAIL ld_w wait: got %b exp 00", {a_bus_valid, a_rsp_valid}); end
      a_bus_rvalid = 1'b1; a_bus_rdata = 64'h89ABCDEF_01234567;
      tick; a_bus_rvalid = 1'b0; a_bus_rdata = 64'd0;
      checks++; if ({a_rsp_valid, a_rsp_rdata} !== {1'b1, 64'hFFFFFFFF89ABCDEF}) begin
         errors++; $display("FAIL ld_w rsp T+3: v %b rdata %h exp 1 ffffffff89abcdef", a_rsp_valid, a_rsp_rdata); end
      tick;
   endtask

   task automatic test_load_split;
      for (int k = 0; k < 2; k++) begin
         logic [63:0] exp_rd;
         exp_rd = (k == 0) ? 64'hFFFFFFFFFFFFFF80 : 64'h000000000000FF80;
         drive_a((k == 0) ? MEM_H : MEM_UH, 64'h3007, 1'b0, 64'd0);
         tick; a_req_valid = 1'b0;
         checks++; if ({a_bus_valid, a_bus_addr} !== {1'b1, 64'h3000}) begin
            errors++; $display("FAIL ld_h%0d beat0: v %b addr %h exp 1 3000", k, a_bus_valid, a_bus_addr); end
         tick;
         a_bus_rvalid = 1'b1; a_bus_rdata = 64'h80123456789ABCDE;
         tick; a_bus_rvalid = 1'b0; a_bus_rdata = 64'd0;
         checks++; if ({a_bus_valid, a_bus_we, a_bus_addr} !== {2'b10, 64'h3008}) begin
            errors++; $display("FAIL ld_h%0d beat1: v %b we %b addr %h exp 1 0 3008", k, a_bus_valid, a_bus_we, a_bus_addr); end
         tick;
         a_bus_rvalid = 1'b1; a_bus_rdata = 64'h55AA55AA55AA55FF;
         checks++; if (a_rsp_valid !== 1'b0) begin errors++; $display("FAIL ld_h%0d early rsp: got %b exp 0", k, a_rsp_valid); end
         tick; a_bus_rvalid = 1'b0; a_bus_rdata = 64'd0;
         checks++; if ({a_rsp_valid, a_rsp_rdata} !== {1'b1, exp_rd}) begin
            errors++; $display("FAIL ld_h%0d rsp T+5: v %b rdata %h exp 1 %h", k, a_rsp_valid, a_rsp_rdata, exp_rd); end
         tick;
      end
   endtask

   task automatic test_mem_no;
      drive_a(MEM_NO, 64'h7003, 1'b0, 64'd0);
      tick; a_req_valid = 1'b0;
      checks++; if ({a_rsp_valid, a_rsp_fault, a_bus_valid, a_rsp_rdata} !== {3'b100, 64'd0}) begin
         errors++; $display("FAIL mem_no rsp: v %b fault %b busv %b rdata %h exp 1 0 0 0",
                            a_rsp_valid, a_rsp_fault, a_bus_valid, a_rsp_rdata); end
      tick;
   endtask

   task automatic test_fault;
      f_req_valid = 1'b1; f_req_op = MEM_W; f_req_addr = 64'h4002; f_req_we = 1'b0;
      tick; f_req_valid = 1'b0;
      checks++; if ({f_bus_valid, f_rsp_valid, f_rsp_fault, f_rsp_rdata} !== {3'b011, 64'd0}) begin
         errors++; $display("FAIL fault T+1: busv %b v %b fault %b rdata %h exp 0 1 1 0",
                            f_bus_valid, f_rsp_valid, f_rsp_fault, f_rsp_rdata); end
      tick;
      checks++; if ({f_bus_valid, f_rsp_valid, f_rsp_fault, f_req_ready} !== 4'b0001) begin
         errors++; $display("FAIL fault after: got %b exp 0001", {f_bus_valid, f_rsp_valid, f_rsp_fault, f_req_ready}); end
   endtask

   task automatic test_stall_reset;
      a_bus_ready = 1'b0;
      drive_a(MEM_D, 64'h2006, 1'b1, 64'h1122334455667788);
      tick; a_req_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         checks++; if ({a_bus_valid, a_req_ready, a_bus_addr, a_bus_wmask, a_bus_wdata} !==
                       {2'b10, 64'h2000, 8'hC0, 64'h7788000000000000}) begin
            errors++; $display("FAIL stall hold %0d: v %b rdy %b addr %h mask %h data %h", i,
                               a_bus_valid, a_req_ready, a_bus_addr, a_bus_wmask, a_bus_wdata); end
         tick;
      end
      a_bus_ready = 1'b1;
      tick;
      checks++; if ({a_bus_valid, a_bus_addr, a_bus_wmask} !== {1'b1, 64'h2008, 8'h3F}) begin
         errors++; $display("FAIL stall beat1: v %b addr %h mask %h exp 1 2008 3f", a_bus_valid, a_bus_addr, a_bus_wmask); end
      tick;
      checks++; if (a_rsp_valid !== 1'b1) begin errors++; $display("FAIL stall rsp: got %b exp 1", a_rsp_valid); end
      tick;
      // same stalled access, aborted by reset in its third cycle
      a_bus_ready = 1'b0;
      drive_a(MEM_D, 64'h2006, 1'b1, 64'h1122334455667788);
      tick; a_req_valid = 1'b0;
      tick; tick;
      checks++; if (a_bus_valid !== 1'b1) begin errors++; $display("FAIL abort pre: busv %b exp 1", a_bus_valid); end
      #2 rstn = 1'b0;
      #1;
      checks++; if ({a_bus_valid, a_req_ready, a_rsp_valid} !== 3'b010) begin
         errors++; $display("FAIL abort async: got %b exp 010", {a_bus_valid, a_req_ready, a_rsp_valid}); end
      tick;
      rstn = 1'b1;
      a_bus_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if ({a_rsp_valid, a_bus_valid, a_req_ready} !== 3'b001) begin
            errors++; $display("FAIL abort post %0d: got %b exp 001", i, {a_rsp_valid, a_bus_valid, a_req_ready}); end
      end
   endtask

   task automatic test_wide_bus;
      x_req_valid = 1'b1; x_req_op = MEM_D; x_req_addr = 64'h5008; x_req_we = 1'b0;
      tick; x_req_valid = 1'b0;
      checks++; if ({x_bus_valid, x_bus_addr, x_bus_wmask} !== {1'b1, 64'h5000, 16'h0000}) begin
         errors++; $display("FAIL wide beat: v %b addr %h mask %h exp 1 5000 0000", x_bus_valid, x_bus_addr, x_bus_wmask); end
      tick;
      x_bus_rvalid = 1'b1; x_bus_rdata = {64'h8123456789ABCDEF, 64'hFFEEDDCCBBAA9988};
      tick; x_bus_rvalid = 1'b0; x_bus_rdata = '0;
      checks++; if ({x_rsp_valid, x_rsp_rdata} !== {1'b1, 64'h8123456789ABCDEF}) begin
         errors++; $display("FAIL wide rsp: v %b rdata %h exp 1 8123456789abcdef", x_rsp_valid, x_rsp_rdata); end
      tick;
   endtask

   initial begin
      rstn = 1'b0;
      a_req_valid = 1'b0; a_req_op = MEM_NO; a_req_addr = '0; a_req_we = 1'b0; a_req_wdata = '0;
      a_bus_ready = 1'b1; a_bus_rvalid = 1'b0; a_bus_rdata = '0;
      f_req_valid = 1'b0; f_req_op = MEM_NO; f_req_addr = '0; f_req_we = 1'b0; f_req_wdata = '0;
      f_bus_ready = 1'b1; f_bus_rvalid = 1'b0; f_bus_rdata = '0;
      x_req_valid = 1'b0; x_req_op = MEM_NO; x_req_addr = '0; x_req_we = 1'b0; x_req_wdata = '0;
      x_bus_ready = 1'b1; x_bus_rvalid = 1'b0; x_bus_rdata = '0;
      #23 rstn = 1'b1;
      tick;
      test_reset();
      test_store_aligned();
      test_store_split();
      test_load_aligned();
      test_load_split();
      test_mem_no();
      test_fault();
      test_stall_reset();
      test_wide_bus();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
